// File: rtl/mul_div_unit.sv
// mul_div_unit: sequential signed multiply/divide producing a 64-bit HI/LO pair.
// Multiply uses radix-2 Booth over 32 iterations; divide uses restoring division
// on operand magnitudes with a sign fix-up pass afterwards.
module mul_div_unit (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        dbz
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state, state_nx;
   logic [4:0]  cnt;
   // acc is one bit wider than the datapath: for multiply it keeps Booth partial
   // sums exact (M = 0x80000000 cannot overflow), for divide it holds the
   // shifted partial remainder, which can reach 2^32 - 1.
   logic [32:0] acc;
   logic [31:0] qr;
   logic [31:0] m;
   logic        qm1;
   logic        op_r;
   logic        sa, sb;

   logic        div_zero;
   logic [31:0] a_mag, b_mag;
   logic [32:0] booth_sum;
   logic [32:0] shifted;
   logic        ge;
   logic [32:0] div_rem;
   logic [31:0] q_fix, r_fix;

   // State register; clr has priority over every clocked transition.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode and status outputs.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      div_zero = op && (b == '0);
      case (state)
         IDLE: if (start) state_nx = div_zero ? DONE : RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == 5'd31) state_nx = FIX;
         end
         FIX: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Per-iteration arithmetic for both Booth multiply and restoring divide.
   always_comb begin
      a_mag = a[31] ? -a : a;
      b_mag = b[31] ? -b : b;
      case ({qr[0], qm1})
         2'b01:   booth_sum = acc + {m[31], m};
         2'b10:   booth_sum = acc - {m[31], m};
         default: booth_sum = acc;
      endcase
      shifted = {acc[31:0], qr[31]};
      ge      = (shifted >= {1'b0, m});
      div_rem = ge ? (shifted - {1'b0, m}) : shifted;
      q_fix   = (sa ^ sb) ? -qr : qr;
      r_fix   = sa ? -acc[31:0] : acc[31:0];
   end

   // Datapath: operand latch, iteration, and result write-back.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt  <= '0;
         acc  <= '0;
         qr   <= '0;
         m    <= '0;
         qm1  <= 1'b0;
         op_r <= 1'b0;
         sa   <= 1'b0;
         sb   <= 1'b0;
         hi   <= '0;
         lo   <= '0;
         dbz  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (div_zero) begin
                     hi  <= a;
                     lo  <= '1;
                     dbz <= 1'b1;
                  end else begin
                     cnt  <= '0;
                     acc  <= '0;
                     qm1  <= 1'b0;
                     op_r <= op;
                     sa   <= a[31];
                     sb   <= b[31];
                     if (op) begin
                        qr <= a_mag;
                        m  <= b_mag;
                     end else begin
                        qr <= b;
                        m  <= a;
                     end
                  end
               end
            end
            RUN: begin
               cnt <= cnt + 5'd1;
               if (op_r) begin
                  acc <= div_rem;
                  qr  <= {qr[30:0], ge};
               end else begin
                  acc <= {booth_sum[32], booth_sum[32:1]};
                  qr  <= {booth_sum[0], qr[31:1]};
                  qm1 <= qr[0];
               end
            end
            FIX: begin
               if (op_r) begin
                  hi <= r_fix;
                  lo <= q_fix;
               end else begin
                  hi <= acc[31:0];
                  lo <= qr;
               end
               dbz <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
